m_store_queue: RTL and testbench

Parametrised memory-stage store unit that aligns sb/sh/sw data into byte lanes, performs address-exception (AdES) checks, and buffers committed stores in a DEPTH-entry FIFO. The FIFO drains to the DM/timer bridge through a req/ack handshake. Stores to a word already queued behind the head are coalesced, and loads that hit a pending store word are flagged so the hazard unit can stall. It sits between the M-stage datapath and the system bridge, replacing direct byteen/wdata drive.

---
 rtl/m_store_queue_pkg.sv | 30 +++
 rtl/m_store_queue_if.sv | 39 +++
 rtl/m_store_queue_store_align.sv | 47 ++++
 rtl/m_store_queue.sv | 152 +++++++++++++++
 tb/tb_m_store_queue.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/m_store_queue_pkg.sv
// Shared constants for the M-stage store queue: store op codes, the
// DM/timer address map, and op-decode helpers.
package m_store_queue_pkg;

    localparam logic [2:0] BE_sw = 3'd1;
    localparam logic [2:0] BE_sh = 3'd2;
    localparam logic [2:0] BE_sb = 3'd3;

    localparam logic [31:0] s_dm  = 32'h0000_0000;
    localparam logic [31:0] e_dm  = 32'h0000_2FFF;
    localparam logic [31:0] s_tc0 = 32'h0000_7F00;
    localparam logic [31:0] e_tc0 = 32'h0000_7F0B;
    localparam logic [31:0] s_tc1 = 32'h0000_7F10;
    localparam logic [31:0] e_tc1 = 32'h0000_7F1B;

    // COUNT register window, as a byte offset from the timer base
    localparam logic [31:0] TC_COUNT_LO = 32'h0000_0008;
    localparam logic [31:0] TC_COUNT_HI = 32'h0000_000B;

    function automatic logic is_store_op(input logic [2:0] op);
        return (op == BE_sw) || (op == BE_sh) || (op == BE_sb);
    endfunction

    function automatic logic in_range(input logic [31:0] addr,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/m_store_queue_if.sv
// M-stage store/load request and bridge drain signals of the store queue.
interface m_store_queue_if #(
    parameter int DATA_W = 32
);
    localparam int LANES = DATA_W / 8;

    logic              st_valid;
    logic [2:0]        st_op;
    logic [31:0]       st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_flush;
    logic              st_ades;
    logic              st_stall;

    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic              ld_conflict;

    logic              mem_req;
    logic [31:0]       mem_addr;
    logic [LANES-1:0]  mem_byteen;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    modport master (
        output st_valid, st_op, st_addr, st_data, st_flush,
        output ld_valid, ld_addr, mem_ack,
        input  st_ades, st_stall, ld_conflict,
        input  mem_req, mem_addr, mem_byteen, mem_wdata
    );

    modport slave (
        input  st_valid, st_op, st_addr, st_data, st_flush,
        input  ld_valid, ld_addr, mem_ack,
        output st_ades, st_stall, ld_conflict,
        output mem_req, mem_addr, mem_byteen, mem_wdata
    );

endinterface

// File: rtl/m_store_queue_store_align.sv
// Combinational lane alignment for sb/sh/sw: places store data at the byte
// lane given by the address offset and flags natural-alignment violations.
module store_align
    import m_store_queue_pkg::*;
#(
    parameter  int DATA_W = 32,
    localparam int LANES  = DATA_W / 8,
    localparam int OFF_W  = $clog2(LANES)
) (
    input  logic [2:0]        i_op,
    input  logic [OFF_W-1:0]  i_off,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_lane_data,
    output logic [LANES-1:0]  o_byteen,
    output logic              o_misalign
);

    logic [LANES-1:0]  w_base_be;
    logic [DATA_W-1:0] w_mask;

    always_comb begin
        w_base_be  = '0;
        w_mask     = '0;
        o_misalign = 1'b0;
        case (i_op)
            BE_sb: begin
                w_base_be = LANES'(4'b0001);
                w_mask    = DATA_W'(32'h0000_00FF);
            end
            BE_sh: begin
                w_base_be  = LANES'(4'b0011);
                w_mask     = DATA_W'(32'h0000_FFFF);
                o_misalign = i_off[0];
            end
            BE_sw: begin
                w_base_be  = LANES'(4'b1111);
                w_mask     = DATA_W'(32'hFFFF_FFFF);
                o_misalign = |i_off[1:0];
            end
            default: ;
        endcase
    end

    assign o_byteen    = w_base_be << i_off;
    assign o_lane_data = (i_data & w_mask) << {i_off, 3'b000};

endmodule

// File: rtl/m_store_queue.sv
// M-stage store queue: AdES checking, lane alignment, a DEPTH-entry FIFO
// with tail coalescing, load-hit detection and req/ack drain to the bridge.
module m_store_queue
    import m_store_queue_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int COALESCE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    m_store_queue_if.slave       io_sq
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]       r_addr [DEPTH];
    logic [LANES-1:0]  r_be   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [DATA_W-1:0] w_al_data;
    logic [LANES-1:0]  w_al_be;
    logic              w_misalign;
    logic              w_is_store;
    logic [31:0]       w_st_word;
    logic [31:0]       w_ld_word;
    logic              w_in_dm;
    logic              w_in_tc0;
    logic              w_in_tc1;
    logic              w_in_tc;
    logic [31:0]       w_tc_off;
    logic              w_count_hit;
    logic              w_ades;
    logic [PTR_W-1:0]  w_tail_last;
    logic              w_coalescible;
    logic              w_stall;
    logic              w_accept;
    logic              w_push;
    logic              w_merge;
    logic              w_pop;
    logic [DATA_W-1:0] w_merged_data;
    logic              w_ld_hit;

    store_align #(.DATA_W(DATA_W)) u_align (
        .i_op        (io_sq.st_op),
        .i_off       (io_sq.st_addr[OFF_W-1:0]),
        .i_data      (io_sq.st_data),
        .o_lane_data (w_al_data),
        .o_byteen    (w_al_be),
        .o_misalign  (w_misalign)
    );

    assign w_is_store = is_store_op(io_sq.st_op);
    assign w_st_word  = {io_sq.st_addr[31:OFF_W], {OFF_W{1'b0}}};
    assign w_ld_word  = {io_sq.ld_addr[31:OFF_W], {OFF_W{1'b0}}};

    // Timers accept only full-word writes and never to their COUNT register
    assign w_in_dm     = in_range(io_sq.st_addr, s_dm, e_dm);
    assign w_in_tc0    = in_range(io_sq.st_addr, s_tc0, e_tc0);
    assign w_in_tc1    = in_range(io_sq.st_addr, s_tc1, e_tc1);
    assign w_in_tc     = w_in_tc0 | w_in_tc1;
    assign w_tc_off    = w_in_tc0 ? (io_sq.st_addr - s_tc0) : (io_sq.st_addr - s_tc1);
    assign w_count_hit = w_in_tc && (w_tc_off >= TC_COUNT_LO) && (w_tc_off <= TC_COUNT_HI);

    assign w_ades = io_sq.st_valid & w_is_store &
                    (w_misalign | ~(w_in_dm | w_in_tc) |
                     (w_in_tc & (io_sq.st_op != BE_sw)) | w_count_hit);

    // count>=2 keeps the merge target off the entry currently on the bus
    assign w_tail_last   = r_tail - PTR_W'(1);
    assign w_coalescible = (COALESCE != 0) && (r_count >= CNT_W'(2)) &&
                           (r_addr[w_tail_last] == w_st_word);

    assign w_stall  = io_sq.st_valid & w_is_store &
                      (r_count == CNT_W'(DEPTH)) & ~w_coalescible;
    assign w_accept = io_sq.st_valid & w_is_store & ~w_ades & ~io_sq.st_flush & ~w_stall;
    assign w_merge  = w_accept & w_coalescible;
    assign w_push   = w_accept & ~w_coalescible;
    assign w_pop    = (r_count != '0) & io_sq.mem_ack;

    always_comb begin
        w_merged_data = r_data[w_tail_last];
        for (int i = 0; i < LANES; i++) begin
            if (w_al_be[i]) begin
                w_merged_data[8*i +: 8] = w_al_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == w_ld_word)) begin
                w_ld_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_be[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_addr[r_head]  <= '0;
                r_be[r_head]    <= '0;
                r_data[r_head]  <= '0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= w_st_word;
                r_be[r_tail]    <= w_al_be;
                r_data[r_tail]  <= w_al_data;
                r_tail          <= r_tail + PTR_W'(1);
            end
            if (w_merge) begin
                r_be[w_tail_last]   <= r_be[w_tail_last] | w_al_be;
                r_data[w_tail_last] <= w_merged_data;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign io_sq.st_ades     = w_ades;
    assign io_sq.st_stall    = w_stall;
    assign io_sq.ld_conflict = io_sq.ld_valid & w_ld_hit;
    assign io_sq.mem_req     = (r_count != '0);
    assign io_sq.mem_addr    = r_addr[r_head];
    assign io_sq.mem_byteen  = r_be[r_head];
    assign io_sq.mem_wdata   = r_data[r_head];

endmodule

// File: tb/tb_m_store_queue.sv
// Directed bench for m_store_queue: alignment, AdES, fill/stall, coalescing,
// load conflicts, flush and mid-drain reset.
module tb_m_store_queue;
    import m_store_queue_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    m_store_queue_if #(.DATA_W(DATA_W)) sq ();

    m_store_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .COALESCE(1)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .io_sq   (sq.slave)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic st(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
        sq.st_valid = 1'b1;
        sq.st_op    = op;
        sq.st_addr  = addr;
        sq.st_data  = data;
        #1;
    endtask

    task automatic idle();
        sq.st_valid = 1'b0;
        sq.st_op    = 3'd0;
        #1;
    endtask

    task automatic head(input string tag, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] data);
        chk({tag, "_req"},  sq.mem_req, 1'b1);
        chk({tag, "_addr"}, sq.mem_addr, addr);
        chk({tag, "_be"},   sq.mem_byteen, be);
        chk({tag, "_data"}, sq.mem_wdata, data);
    endtask

    task automatic ades_case(input string tag, input logic [2:0] op, input logic [31:0] addr);
        st(op, addr, 32'h0BAD_0BAD);
        chk({tag, "_ades"}, sq.st_ades, 1'b1);
        tick();
        idle();
        chk({tag, "_noq"}, sq.mem_req, 1'b0);
    endtask

    initial begin
        sq.st_valid = 1'b0;
        sq.st_op    = 3'd0;
        sq.st_addr  = '0;
        sq.st_data  = '0;
        sq.st_flush = 1'b0;
        sq.ld_valid = 1'b0;
        sq.ld_addr  = '0;
        sq.mem_ack  = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        chk("rst_req",   sq.mem_req, 1'b0);
        chk("rst_addr",  sq.mem_addr, 32'h0);
        chk("rst_be",    sq.mem_byteen, 4'h0);
        chk("rst_data",  sq.mem_wdata, 32'h0);
        chk("rst_count", dut.r_count, 0);

        // alignment with ack every cycle
        sq.mem_ack = 1'b1;
        st(BE_sb, 32'h0003, 32'h1234_56AB);
        chk("sb_ades",  sq.st_ades, 1'b0);
        chk("sb_stall", sq.st_stall, 1'b0);
        chk("pre_req",  sq.mem_req, 1'b0);
        tick();
        st(BE_sh, 32'h0012, 32'hFFFF_1234);
        head("sb", 32'h0000, 4'b1000, 32'hAB00_0000);
        tick();
        st(BE_sw, 32'h0020, 32'hDEAD_BEEF);
        head("sh", 32'h0010, 4'b1100, 32'h1234_0000);
        tick();
        idle();
        head("sw", 32'h0020, 4'b1111, 32'hDEAD_BEEF);
        tick();
        chk("drained_req", sq.mem_req, 1'b0);
        sq.mem_ack = 1'b0;

        // address exceptions
        ades_case("sw_mis",   BE_sw, 32'h0002);
        ades_case("sh_mis",   BE_sh, 32'h0001);
        ades_case("sb_tc",    BE_sb, 32'h7F00);
        ades_case("sw_count", BE_sw, 32'h7F08);
        ades_case("sw_oor",   BE_sw, 32'h9000);

        // legal timer store but flushed
        sq.st_flush = 1'b1;
        st(BE_sw, 32'h7F04, 32'h0000_0042);
        chk("flush_ades", sq.st_ades, 1'b0);
        tick();
        sq.st_flush = 1'b0;
        idle();
        chk("flush_noq", sq.mem_req, 1'b0);

        // fill to DEPTH, then stall
        for (int i = 0; i < DEPTH; i++) begin
            st(BE_sw, 32'h0100 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            tick();
        end
        chk("full_count", dut.r_count, DEPTH);
        st(BE_sw, 32'h0110, 32'h0000_0055);
        chk("full_stall", sq.st_stall, 1'b1);
        tick();
        chk("full_stall2", sq.st_stall, 1'b1);
        head("full_hold", 32'h0100, 4'b1111, 32'h1000_0000);
        st(BE_sb, 32'h010D, 32'h0000_00CC);
        chk("full_coal_nostall", sq.st_stall, 1'b0);
        tick();
        chk("full_coal_count", dut.r_count, DEPTH);
        st(BE_sw, 32'h0110, 32'h0000_0055);
        sq.mem_ack = 1'b1;
        #1;
        chk("ack_stall_same", sq.st_stall, 1'b1);
        tick();
        sq.mem_ack = 1'b0;
        #1;
        chk("ack_stall_drop", sq.st_stall, 1'b0);
        tick();
        idle();
        chk("refill_count", dut.r_count, DEPTH);
        sq.mem_ack = 1'b1;
        #1;
        head("d0", 32'h0104, 4'b1111, 32'h1000_0001);
        tick();
        head("d1", 32'h0108, 4'b1111, 32'h1000_0002);
        tick();
        head("d2", 32'h010C, 4'b1111, 32'h1000_CC03);
        tick();
        head("d3", 32'h0110, 4'b1111, 32'h0000_0055);
        tick();
        chk("fill_drained", sq.mem_req, 1'b0);
        sq.mem_ack = 1'b0;

        // coalescing into the tail
        st(BE_sw, 32'h0040, 32'h1111_1111);
        tick();
        st(BE_sb, 32'h0044, 32'h0000_00FF);
        tick();
        st(BE_sb, 32'h0045, 32'h0000_00EE);
        chk("coal_stall", sq.st_stall, 1'b0);
        tick();
        idle();
        chk("coal_count", dut.r_count, 2);
        sq.ld_valid = 1'b1;
        sq.ld_addr  = 32'h0046;
        #1;
        chk("ld_hit46", sq.ld_conflict, 1'b1);
        sq.ld_addr = 32'h0048;
        #1;
        chk("ld_miss48", sq.ld_conflict, 1'b0);
        sq.ld_addr = 32'h0040;
        #1;
        chk("ld_hit_head", sq.ld_conflict, 1'b1);
        sq.mem_ack = 1'b1;
        #1;
        head("c0", 32'h0040, 4'b1111, 32'h1111_1111);
        tick();
        head("c1", 32'h0044, 4'b0011, 32'h0000_EEFF);
        chk("ld_popped40", sq.ld_conflict, 1'b0);
        sq.ld_addr = 32'h0046;
        #1;
        chk("ld_hit46_b", sq.ld_conflict, 1'b1);
        tick();
        sq.mem_ack = 1'b0;
        #1;
        chk("coal_drained", sq.mem_req, 1'b0);
        chk("ld_after_drain", sq.ld_conflict, 1'b0);
        sq.ld_valid = 1'b0;

        // reset with entries pending
        for (int i = 0; i < 3; i++) begin
            st(BE_sw, 32'h0200 + 32'(4 * i), 32'hC0DE_0000 + 32'(i));
            tick();
        end
        idle();
        chk("pend_count", dut.r_count, 3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mrst_req",   sq.mem_req, 1'b0);
        chk("mrst_count", dut.r_count, 0);
        chk("mrst_be",    sq.mem_byteen, 4'h0);
        chk("mrst_data",  sq.mem_wdata, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
